// File: rtl/decoded_data_axil_arbiter.sv
// rtl/decoded_data_axil_arbiter.sv - two-port AXI4-Lite arbiter in front of the decoded_data_mem_map slave
module decoded_data_axil_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic [2:0]                s0_awprot,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic [2:0]                s0_arprot,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic [2:0]                s1_awprot,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic [2:0]                s1_arprot,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [1:0]                grant,
  output logic                      busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  state_t     state;
  logic       sel;
  logic       last_port;
  logic [1:0] last_wr;  // per port: 1 = last served transaction was a write
  logic       aw_done, w_done, ar_done;

  logic [ADDR_WIDTH-1:0]   s_awaddr [2];
  logic [2:0]              s_awprot [2];
  logic [DATA_WIDTH-1:0]   s_wdata  [2];
  logic [DATA_WIDTH/8-1:0] s_wstrb  [2];
  logic [ADDR_WIDTH-1:0]   s_araddr [2];
  logic [2:0]              s_arprot [2];
  logic [1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

  logic [1:0]              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]              s_bresp  [2];
  logic [DATA_WIDTH-1:0]   s_rdata  [2];
  logic [1:0]              s_rresp  [2];

  assign s_awaddr  = '{s0_awaddr, s1_awaddr};
  assign s_awprot  = '{s0_awprot, s1_awprot};
  assign s_wdata   = '{s0_wdata, s1_wdata};
  assign s_wstrb   = '{s0_wstrb, s1_wstrb};
  assign s_araddr  = '{s0_araddr, s1_araddr};
  assign s_arprot  = '{s0_arprot, s1_arprot};
  assign s_awvalid = {s1_awvalid, s0_awvalid};
  assign s_wvalid  = {s1_wvalid, s0_wvalid};
  assign s_bready  = {s1_bready, s0_bready};
  assign s_arvalid = {s1_arvalid, s0_arvalid};
  assign s_rready  = {s1_rready, s0_rready};

  assign s0_awready = s_awready[0];
  assign s1_awready = s_awready[1];
  assign s0_wready  = s_wready[0];
  assign s1_wready  = s_wready[1];
  assign s0_bvalid  = s_bvalid[0];
  assign s1_bvalid  = s_bvalid[1];
  assign s0_bresp   = s_bresp[0];
  assign s1_bresp   = s_bresp[1];
  assign s0_arready = s_arready[0];
  assign s1_arready = s_arready[1];
  assign s0_rvalid  = s_rvalid[0];
  assign s1_rvalid  = s_rvalid[1];
  assign s0_rdata   = s_rdata[0];
  assign s1_rdata   = s_rdata[1];
  assign s0_rresp   = s_rresp[0];
  assign s1_rresp   = s_rresp[1];

  logic [1:0] wreq, rreq, req;
  logic       pick_port, pick_wr;

  assign wreq = s_awvalid & s_wvalid;
  assign rreq = s_arvalid;
  assign req  = wreq | rreq;

  always_comb begin
    pick_port = (req[0] & req[1]) ? ~last_port : req[1];
    if (wreq[pick_port] & rreq[pick_port])
      pick_wr = ~last_wr[pick_port];
    else
      pick_wr = wreq[pick_port];
  end

  assign busy  = (state != ST_IDLE);
  assign grant = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // Everything below is gated by the registered state, so IDLE never passes a valid through.
  always_comb begin
    m_awaddr  = '0;
    m_awprot  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_araddr  = '0;
    m_arprot  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_arready = '0;
    s_rvalid  = '0;
    s_bresp   = '{2'b00, 2'b00};
    s_rdata   = '{'0, '0};
    s_rresp   = '{2'b00, 2'b00};
    if (state != ST_IDLE) begin
      m_awaddr = s_awaddr[sel];
      m_awprot = s_awprot[sel];
      m_wdata  = s_wdata[sel];
      m_wstrb  = s_wstrb[sel];
      m_araddr = s_araddr[sel];
      m_arprot = s_arprot[sel];
    end
    if (state == ST_WR) begin
      m_awvalid      = s_awvalid[sel] & ~aw_done;
      m_wvalid       = s_wvalid[sel] & ~w_done;
      s_awready[sel] = m_awready & ~aw_done;
      s_wready[sel]  = m_wready & ~w_done;
      s_bvalid[sel]  = m_bvalid & aw_done & w_done;
      m_bready       = s_bready[sel] & aw_done & w_done;
      s_bresp[sel]   = m_bresp;
    end
    if (state == ST_RD) begin
      m_arvalid      = s_arvalid[sel] & ~ar_done;
      s_arready[sel] = m_arready & ~ar_done;
      s_rvalid[sel]  = m_rvalid & ar_done;
      m_rready       = s_rready[sel] & ar_done;
      s_rdata[sel]   = m_rdata;
      s_rresp[sel]   = m_rresp;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      sel       <= 1'b0;
      last_port <= 1'b1;
      last_wr   <= 2'b00;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            sel   <= pick_port;
            state <= pick_wr ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          if (m_awvalid & m_awready) aw_done <= 1'b1;
          if (m_wvalid & m_wready)   w_done  <= 1'b1;
          if (m_bvalid & m_bready) begin
            state        <= ST_IDLE;
            last_port    <= sel;
            last_wr[sel] <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end
        end
        ST_RD: begin
          if (m_arvalid & m_arready) ar_done <= 1'b1;
          if (m_rvalid & m_rready) begin
            state        <= ST_IDLE;
            last_port    <= sel;
            last_wr[sel] <= 1'b0;
            ar_done      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
